async_fifo: RTL and testbench

- Single-clock, first-in-first-out data buffer, DEPTH = 2^ADDR_WIDTH entries, between a producer and a consumer in the same clock domain.
- Writes are accepted when not full; reads are accepted when not empty.
- Read data is registered, so it appears one cycle after the accepted read.
- full and empty are exact, registered status flags.

---
 rtl/async_fifo_pkg.sv | 27 ++
 rtl/async_fifo_mem.sv | 41 ++++
 rtl/async_fifo.sv | 86 ++++++++
 tb/tb_async_fifo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared defaults and pointer-compare helpers for the single-clock FIFO.
// Optional occupancy output is enabled by defining ASYNC_FIFO_LEVEL_EN.
package async_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 4;

    // Pointers are zero-extended into this word so the helpers stay width-agnostic.
    typedef logic [31:0] ptr_word_t;

    function automatic logic ptr_full(input ptr_word_t wp, input ptr_word_t rp,
                                      input logic [4:0] aw);
        ptr_word_t diff;
        ptr_word_t lo_mask;
        diff    = wp ^ rp;
        lo_mask = (ptr_word_t'(1) << aw) - ptr_word_t'(1);
        return ((diff & lo_mask) == '0) && diff[aw];
    endfunction

    function automatic logic ptr_empty(input ptr_word_t wp, input ptr_word_t rp,
                                       input logic [4:0] aw);
        ptr_word_t ptr_mask;
        ptr_mask = (ptr_word_t'(1) << (aw + 5'd1)) - ptr_word_t'(1);
        return ((wp ^ rp) & ptr_mask) == '0;
    endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read that
// holds its last value when no read is requested.
module async_fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with exact registered full/empty and one-cycle read data.
// Define ASYNC_FIFO_LEVEL_EN to add the registered occupancy output 'level'.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
`ifdef ASYNC_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam logic [4:0] AW = 5'(ADDR_WIDTH);

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH:0] w_rd_ptr_nxt;
    logic                r_full;
    logic                r_empty;

    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    assign w_wr_ptr_nxt = w_wr_acc ? r_wr_ptr + 1'b1 : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd_acc ? r_rd_ptr + 1'b1 : r_rd_ptr;

    // Flags come from next-state pointers so they are exact on the edge they update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_full   <= ptr_full(ptr_word_t'(w_wr_ptr_nxt), ptr_word_t'(w_rd_ptr_nxt), AW);
            r_empty  <= ptr_empty(ptr_word_t'(w_wr_ptr_nxt), ptr_word_t'(w_rd_ptr_nxt), AW);
        end
    end

    assign full  = r_full;
    assign empty = r_empty;

`ifdef ASYNC_FIFO_LEVEL_EN
    logic [ADDR_WIDTH:0] r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            r_level <= w_wr_ptr_nxt - w_rd_ptr_nxt;
        end
    end

    assign level = r_level;
`endif

    async_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (din),
        .re    (w_rd_acc),
        .raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (dout)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: constant vector table plus a queue
// scoreboard that predicts dout/full/empty from accepted writes and reads.
module tb_async_fifo;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
`ifdef ASYNC_FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    async_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (din),
        .rd_en (rd_en),
        .dout  (dout),
        .full  (full),
        .empty (empty)
`ifdef ASYNC_FIFO_LEVEL_EN
        ,
        .level (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            rx_count = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_dout = '0;

    typedef struct {
        logic          we;
        logic [DW-1:0] d;
        logic          re;
        logic [DW-1:0] exp_dout;
        logic          exp_empty;
        logic          exp_full;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // One clock of stimulus; the scoreboard decides acceptance from its own occupancy.
    task automatic cycle(input logic we, input logic [DW-1:0] d, input logic re,
                         output logic w_ok);
        logic r_ok;
        wr_en = we;
        din   = d;
        rd_en = re;
        w_ok  = we && (sb_q.size() < DEPTH);
        r_ok  = re && (sb_q.size() > 0);
        if (r_ok) begin
            exp_dout = sb_q.pop_front();
            rx_count++;
        end
        if (w_ok) sb_q.push_back(d);
        @(posedge clk);
        #1;
        chk("sb_dout", dout, exp_dout);
        chk("sb_empty", {31'd0, empty}, {31'd0, sb_q.size() == 0});
        chk("sb_full", {31'd0, full}, {31'd0, sb_q.size() == DEPTH});
`ifdef ASYNC_FIFO_LEVEL_EN
        chk("sb_level", DW'(level), DW'(sb_q.size()));
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic          ok;
        int            next_i;
        logic [DW-1:0] base;
        base = 32'h1A2B_0000;

        vecs[0] = '{1'b1, 32'h1A2B_0000, 1'b0, 32'h0000_0000,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h1A2B_0000,  1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h1A2B_0000,  1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0055, 1'b1, 32'h1A2B_0000,  1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0066, 1'b1, 32'h0000_0055,  1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 32'h0000_0066,  1'b1, 1'b0};

        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_dout", dout, 32'h0);
        chk("reset_empty", {31'd0, empty}, 32'd1);
        chk("reset_full", {31'd0, full}, 32'd0);
`ifdef ASYNC_FIFO_LEVEL_EN
        chk("reset_level", DW'(level), 32'd0);
`endif
        rst = 1'b0;

        // Single write/read, read while empty, write+read while empty.
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].we, vecs[i].d, vecs[i].re, ok);
            chk("vec_dout", dout, vecs[i].exp_dout);
            chk("vec_empty", {31'd0, empty}, {31'd0, vecs[i].exp_empty});
            chk("vec_full", {31'd0, full}, {31'd0, vecs[i].exp_full});
        end

        // Fill to full, overflow write dropped, drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, base + DW'(i), 1'b0, ok);
        chk("fill_full", {31'd0, full}, 32'd1);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, ok);
        chk("overflow_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, ok);
            chk("drain_order", dout, base + DW'(i));
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);
        cycle(1'b0, '0, 1'b1, ok);
        chk("underflow_hold", dout, base + 32'd15);

        // Streaming with wrap and irregular consumer.
        rx_count = 0;
        next_i   = 0;
        for (int cyc = 0; cyc < 2000 && rx_count < 64; cyc++) begin
            cycle(next_i < 64, base + DW'(next_i), $urandom_range(0, 2) != 0, ok);
            if (ok) next_i++;
        end
        chk("stream_rx_count", DW'(rx_count), 32'd64);

        // Simultaneous access at occupancy 8.
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'hA000_0000 + DW'(i), 1'b0, ok);
        cycle(1'b1, 32'hA000_0008, 1'b1, ok);
        chk("simul_dout", dout, 32'hA000_0000);
        chk("simul_empty", {31'd0, empty}, 32'd0);
        chk("simul_full", {31'd0, full}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, '0, 1'b1, ok);
            chk("simul_drain", dout, 32'hA000_0000 + DW'(i));
        end
        chk("simul_drained_empty", {31'd0, empty}, 32'd1);

        // Reset pulse mid-stream, checked before any clock edge.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hB000_0000 + DW'(i), i == 2, ok);
        chk("pre_rst_empty", {31'd0, empty}, 32'd0);
        rst = 1'b1;
        #2;
        chk("async_rst_empty", {31'd0, empty}, 32'd1);
        chk("async_rst_dout", dout, 32'h0);
        chk("async_rst_full", {31'd0, full}, 32'd0);
        sb_q.delete();
        exp_dout = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 32'hCAFE_0001, 1'b0, ok);
        cycle(1'b1, 32'hCAFE_0002, 1'b1, ok);
        chk("post_rst_first", dout, 32'hCAFE_0001);
        cycle(1'b0, '0, 1'b1, ok);
        chk("post_rst_second", dout, 32'hCAFE_0002);
        chk("post_rst_empty", {31'd0, empty}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
